mul_sequencer: RTL and testbench

- Iterative multiply unit for the RISC-V i16 ALU. Computes one partial-product row per cycle using a single W-bit shift-add datapath, instead of the W-row combinational array.
- Supports the four RISC-V M multiply ops (MUL, MULH, MULHSU, MULHU).
- Connects to the issue stage via valid/ready on the input and valid/ready on the output.
- Fixed latency, with a kill input for pipeline flush.

---
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/mul_sequencer.sv | 112 +++++++++++
 tb/tb_mul_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Issue-side and writeback-side handshake bundle for the iterative multiplier.
// The requester drives master; the multiply unit sits on slave.
interface mul_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for RISC-V MUL/MULH/MULHSU/MULHU.
// Sign-magnitude on accept, WIDTH add/shift steps, a fix-up negate, then a registered result.
module mul_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    mul_sequencer_if.slave  bus
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         state;
    logic [1:0]     op_q;
    logic [W-1:0]   mcand;
    logic [W-1:0]   acc_hi;
    logic [W-1:0]   mplier;
    logic           neg;
    logic [CW-1:0]  cnt;
    logic           ready_q;
    logic           valid_q;
    logic           busy_q;
    logic [W-1:0]   result_q;

    logic           sa;
    logic           sb;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     sum;
    logic [2*W-1:0] prod_neg;

    // Operand sign extraction and magnitude; the most negative value maps to itself as unsigned.
    assign sa    = ((bus.op == 2'b01) || (bus.op == 2'b10)) && bus.a[W-1];
    assign sb    = (bus.op == 2'b01) && bus.b[W-1];
    assign mag_a = sa ? (~bus.a + W'(1)) : bus.a;
    assign mag_b = sb ? (~bus.b + W'(1)) : bus.b;

    assign sum      = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    assign prod_neg = ~{acc_hi, mplier} + (2*W)'(1);

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            mcand    <= '0;
            acc_hi   <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.kill) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        op_q    <= bus.op;
                        mcand   <= mag_a;
                        mplier  <= mag_b;
                        acc_hi  <= '0;
                        neg     <= sa ^ sb;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    // Carry lands in acc_hi MSB; acc_hi LSB shifts into the vacated multiplier bit.
                    acc_hi <= sum[W:1];
                    mplier <= {sum[0], mplier[W-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (neg) begin
                        {acc_hi, mplier} <= prod_neg;
                    end
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle registers the selected half; afterwards wait for the consumer.
                    if (!valid_q) begin
                        valid_q  <= 1'b1;
                        result_q <= (op_q == 2'b00) ? mplier : acc_hi;
                    end else if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized and directed bench for mul_sequencer against an integer-arithmetic reference.
module tb_mul_sequencer;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mul_sequencer_if #(.WIDTH(W)) bus ();

    mul_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: extend operands per op signedness, multiply as 64-bit integers, pick a half.
    function automatic logic [W-1:0] ref_mul(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint av, bv, p;
        av = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'(a);
        bv = (op == 2'b01) ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        return (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Issue one request, wait for the result, optionally stall the consumer, then take it.
    task automatic transact(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int stall);
        logic [W-1:0] exp;
        int           lat;
        logic         ready_seen;
        exp = ref_mul(op, a, b);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        bus.out_ready = (stall == 0);
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.op = 2'($urandom);
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        lat = 0;
        ready_seen = 1'b0;
        while (!bus.out_valid && lat < int'(W) + 10) begin
            ready_seen |= bus.in_ready;
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(W + 2));
        check("in_ready_low", 32'(ready_seen), 32'd0);
        check("result", 32'(bus.result), 32'(exp));
        check("busy_done", 32'(bus.busy), 32'd1);
        if (stall > 0) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                tick();
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_result", 32'(bus.result), 32'(exp));
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
        end
        tick();
        check("post_xfer_valid", 32'(bus.out_valid), 32'd0);
        check("post_xfer_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    // Start an op, abort after `wait_cycles` (or in DONE if negative), via kill or rst.
    task automatic abort_op(input int wait_cycles, input logic use_rst);
        logic seen;
        int   n;
        bus.op = 2'b01;
        bus.a = 16'h1234;
        bus.b = 16'h5678;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        if (wait_cycles >= 0) begin
            for (int i = 0; i < wait_cycles; i++) tick();
            check("pre_abort_valid", 32'(bus.out_valid), 32'd0);
        end else begin
            n = 0;
            while (!bus.out_valid && n < int'(W) + 10) begin
                tick();
                n++;
            end
            check("pre_abort_done", 32'(bus.out_valid), 32'd1);
        end
        if (use_rst) rst = 1'b1;
        else bus.kill = 1'b1;
        tick();
        rst = 1'b0;
        bus.kill = 1'b0;
        check_idle(use_rst ? "rst_abort" : "kill_abort");
        if (use_rst) check("rst_result", 32'(bus.result), 32'd0);
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < int'(W) + 6; i++) begin
            tick();
            seen |= bus.out_valid;
        end
        check("no_result_after_abort", 32'(seen), 32'd0);
        transact(2'b00, 16'd7, 16'd9, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.kill = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        check("reset_result", 32'(bus.result), 32'd0);
        rst = 1'b0;
        tick();

        transact(2'b00, 16'h0003, 16'h0005, 0);
        check("mul_3x5_ref", 32'(ref_mul(2'b00, 16'h0003, 16'h0005)), 32'h000F);
        transact(2'b01, 16'hFFFE, 16'h0003, 0);
        transact(2'b01, 16'h8000, 16'h8000, 0);
        transact(2'b11, 16'hFFFF, 16'hFFFF, 0);
        transact(2'b00, 16'hFFFF, 16'hFFFF, 0);
        transact(2'b10, 16'h8000, 16'hFFFF, 0);
        transact(2'b10, 16'hFFFF, 16'h8000, 2);
        transact(2'b01, 16'h0000, 16'hFFFF, 0);
        transact(2'b11, 16'h1234, 16'h0000, 5);

        // kill on an IDLE request must prevent the accept
        bus.in_valid = 1'b1;
        bus.kill = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.kill = 1'b0;
        check_idle("kill_idle");

        abort_op(7, 1'b0);
        abort_op(-1, 1'b0);
        abort_op(7, 1'b1);
        abort_op(-1, 1'b1);

        for (int t = 0; t < 60; t++) begin
            transact(2'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end
        for (int t = 0; t < 8; t++) begin
            transact(2'($urandom), (t[0] ? 16'h8000 : 16'hFFFF), (t[1] ? 16'h8000 : 16'h0001), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
